// File: rtl/prbs_framer_pkg.sv
// ----------------------------------------------------------------------------
// prbs_framer_pkg
//   Shared definitions for the PRBS framer:
//     state_t      - framer FSM state encoding (IDLE, LOAD, SHIFT, HOLD)
//     default_taps - Galois feedback taps for common LFSR lengths (LSB-aligned)
// ----------------------------------------------------------------------------
package prbs_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Right-shifting Galois taps; bit LN-1 is always set so the register
    // stays full-length. Unlisted lengths fall back to the 8-bit polynomial.
    function automatic logic [31:0] default_taps(input int ln);
        logic [31:0] taps;
        case (ln)
            4:       taps = 32'h0000_000c;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00b4;
            16:      taps = 32'h0000_b400;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_00b4;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_gal_ld.sv
// ----------------------------------------------------------------------------
// lfsr_gal_ld
//   Loadable right-shifting Galois LFSR. Emits lfsr[0] as the current bit;
//   each enabled step shifts right and XORs TAPS in when the emitted bit is 1.
//   Ports:
//     i_clk, i_reset  clock, synchronous active-high reset (LFSR <= 1)
//     i_load          load i_seed (a zero seed becomes 1 to avoid lock-up)
//     i_seed [LN]     seed value
//     i_ce            advance one step
//     o_bit           current output bit (lfsr[0])
// ----------------------------------------------------------------------------
module lfsr_gal_ld #(
    parameter int              LN   = 8,
    parameter logic [LN-1:0]   TAPS = 8'hb4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [LN-1:0] i_seed,
    input  logic          i_ce,
    output logic          o_bit
);

    logic [LN-1:0] lfsr;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr <= LN'(1);
        end else if (i_load) begin
            lfsr <= (i_seed == '0) ? LN'(1) : i_seed;
        end else if (i_ce) begin
            if (lfsr[0])
                lfsr <= {1'b0, lfsr[LN-1:1]} ^ TAPS;
            else
                lfsr <= {1'b0, lfsr[LN-1:1]};
        end
    end

    assign o_bit = lfsr[0];

endmodule

// File: rtl/prbs_framer.sv
// ----------------------------------------------------------------------------
// prbs_framer
//   Generates frames of PRBS words. On an accepted start it seeds a Galois
//   LFSR, shifts OW bits into a word (first bit lands in o_data[0]), and
//   offers each word on a valid/ready stream; o_last marks the final word of
//   an i_len-word frame. The LFSR runs continuously across a frame.
//   Ports:
//     i_clk, i_reset   clock, synchronous active-high reset
//     i_start          start request (IDLE only, needs i_len != 0)
//     i_abort          terminate the current frame, return to IDLE
//     i_seed [LN]      seed sampled with an accepted start
//     i_len  [LGFRAME] words per frame, sampled with an accepted start
//     o_busy           FSM not in IDLE
//     o_valid, i_ready output handshake
//     o_data [OW]      packed PRBS word
//     o_last           final word of the frame (qualified by o_valid)
// ----------------------------------------------------------------------------
module prbs_framer
    import prbs_framer_pkg::*;
#(
    parameter int            LN      = 8,
    parameter logic [LN-1:0] TAPS    = LN'(default_taps(LN)),
    parameter int            OW      = 8,
    parameter int            LGFRAME = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [LN-1:0]      i_seed,
    input  logic [LGFRAME-1:0] i_len,
    output logic               o_busy,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [OW-1:0]      o_data,
    output logic               o_last
);

    localparam int            BW       = $clog2(OW + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(OW - 1);

    state_t             state, state_nxt;
    logic [LN-1:0]      seed_q;
    logic [LGFRAME-1:0] remaining;
    logic [BW-1:0]      bit_cnt;
    logic [OW-1:0]      word;
    logic               lfsr_bit;

    logic start_ok, shift_en, last_shift, handshake, final_word;

    assign start_ok   = i_start && !i_abort && (i_len != '0);
    // An abort freezes the LFSR and word register where they are.
    assign shift_en   = (state == ST_SHIFT) && !i_abort;
    assign last_shift = shift_en && (bit_cnt == LAST_BIT);
    assign handshake  = (state == ST_HOLD) && i_ready;
    assign final_word = (remaining == LGFRAME'(1));

    lfsr_gal_ld #(
        .LN   (LN),
        .TAPS (TAPS)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  ((state == ST_LOAD) && !i_abort),
        .i_seed  (seed_q),
        .i_ce    (shift_en),
        .o_bit   (lfsr_bit)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: next-state is assigned a default before the case so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok)   state_nxt = ST_LOAD;
            ST_LOAD:                  state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_nxt = ST_HOLD;
            ST_HOLD:  if (i_ready)    state_nxt = final_word ? ST_IDLE : ST_SHIFT;
            default:                  state_nxt = ST_IDLE;
        endcase
        if (i_abort && (state != ST_IDLE))
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seed_q    <= '0;
            remaining <= '0;
            bit_cnt   <= '0;
            word      <= '0;
            o_data    <= '0;
        end else begin
            if ((state == ST_IDLE) && start_ok) begin
                seed_q    <= i_seed;
                remaining <= i_len;
            end
            if (state == ST_LOAD)
                bit_cnt <= '0;
            if (shift_en) begin
                word    <= {lfsr_bit, word[OW-1:1]};
                bit_cnt <= last_shift ? '0 : bit_cnt + BW'(1);
            end
            // Publish the completed word, including the bit shifted this cycle.
            if (last_shift)
                o_data <= {lfsr_bit, word[OW-1:1]};
            // A handshake coinciding with an abort still consumes the word.
            if (handshake)
                remaining <= remaining - LGFRAME'(1);
        end
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_valid = (state == ST_HOLD);
    assign o_last  = o_valid && final_word;

endmodule

// File: tb/tb_prbs_framer.sv
// ----------------------------------------------------------------------------
// tb_prbs_framer
//   Self-checking bench for prbs_framer (LN=8, TAPS=8'hb4, OW=8, LGFRAME=8).
//   Expected words are queued when a frame is started; an independent monitor
//   pops and compares on every accepted output word.
// ----------------------------------------------------------------------------
module tb_prbs_framer;

    logic       clk;
    logic       i_reset;
    logic       i_start;
    logic       i_abort;
    logic [7:0] i_seed;
    logic [7:0] i_len;
    logic       o_busy;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_last;

    int n_checks = 0;
    int n_fail   = 0;

    // {last, data}
    logic [8:0] exp_q[$];

    prbs_framer #(
        .LN      (8),
        .TAPS    (8'hb4),
        .OW      (8),
        .LGFRAME (8)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_abort (i_abort),
        .i_seed  (i_seed),
        .i_len   (i_len),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: sample mid-cycle, pop on every accepted word.
    always @(negedge clk) begin
        if (!i_reset && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {23'd0, o_last, o_data}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("word_data", {24'd0, o_data}, {24'd0, e[7:0]});
                check("word_last", {31'd0, o_last}, {31'd0, e[8]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] seed, input logic [7:0] len);
        i_seed  = seed;
        i_len   = len;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic push_std_frame();
        exp_q.push_back({1'b0, 8'h29});
        exp_q.push_back({1'b1, 8'hff});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 100) begin
            tick();
            n++;
        end
        check(name, (n < 100) ? 32'd1 : 32'd0, 32'd1);
        check({name, "_idle_busy"},  {31'd0, o_busy},  32'd0);
        check({name, "_idle_valid"}, {31'd0, o_valid}, 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!o_valid && n < 40) begin
            tick();
            n++;
        end
        check(name, {31'd0, o_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_seed  = 8'h00;
        i_len   = 8'h00;
        i_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_busy",  {31'd0, o_busy},  32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_last",  {31'd0, o_last},  32'd0);
        check("rst_data",  {24'd0, o_data},  32'd0);
        i_reset = 1'b0;
        tick();

        // Case 1: seed 01, two words, ready high; also first-word latency
        push_std_frame();
        start_frame(8'h01, 8'd2);
        check("c1_busy_after_start", {31'd0, o_busy}, 32'd1);
        repeat (8) tick();
        check("c1_latency_early", {31'd0, o_valid}, 32'd0);
        tick();
        check("c1_latency_valid", {31'd0, o_valid}, 32'd1);
        wait_done("c1_done");

        // Case 2: zero seed behaves like seed 01
        push_std_frame();
        start_frame(8'h00, 8'd2);
        wait_done("c2_done");

        // Case 3: back-pressure in HOLD for 5 cycles
        i_ready = 1'b0;
        push_std_frame();
        start_frame(8'h01, 8'd2);
        wait_valid("c3_valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("c3_hold_valid", {31'd0, o_valid}, 32'd1);
            check("c3_hold_data",  {24'd0, o_data},  32'h29);
            check("c3_hold_last",  {31'd0, o_last},  32'd0);
        end
        i_ready = 1'b1;
        wait_done("c3_done");

        // Case 4: zero-length start ignored; start while busy ignored
        start_frame(8'h01, 8'd0);
        check("c4_len0_busy", {31'd0, o_busy}, 32'd0);
        repeat (3) tick();
        check("c4_len0_still_idle", {31'd0, o_busy}, 32'd0);
        push_std_frame();
        start_frame(8'h01, 8'd2);
        repeat (3) tick();
        start_frame(8'h55, 8'd5);
        check("c4_busy_start_busy", {31'd0, o_busy}, 32'd1);
        wait_done("c4_done");

        // Case 5: abort while shifting word1
        exp_q.push_back({1'b0, 8'h29});
        start_frame(8'h01, 8'd2);
        wait_valid("c5_valid_word0");
        tick();
        repeat (3) tick();
        check("c5_shifting_busy", {31'd0, o_busy}, 32'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("c5_abort_busy",  {31'd0, o_busy},  32'd0);
        check("c5_abort_valid", {31'd0, o_valid}, 32'd0);
        check("c5_abort_data",  {24'd0, o_data},  32'h29);
        repeat (12) tick();
        check("c5_queue_drained", exp_q.size(), 32'd0);
        exp_q.push_back({1'b1, 8'h29});
        start_frame(8'h01, 8'd1);
        wait_done("c5_restart_done");

        // Case 6: reset while holding a word
        i_ready = 1'b0;
        push_std_frame();
        start_frame(8'h01, 8'd2);
        wait_valid("c6_valid");
        repeat (2) tick();
        i_reset = 1'b1;
        tick();
        exp_q.delete();
        check("c6_rst_busy",  {31'd0, o_busy},  32'd0);
        check("c6_rst_valid", {31'd0, o_valid}, 32'd0);
        check("c6_rst_last",  {31'd0, o_last},  32'd0);
        check("c6_rst_data",  {24'd0, o_data},  32'd0);
        i_reset = 1'b0;
        i_ready = 1'b1;
        tick();
        push_std_frame();
        start_frame(8'h01, 8'd2);
        wait_done("c6_after_reset_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
